// File: rtl/db_pkg.sv
// Shared deblocking constants: top-row word counts and colour component encodings.
package db_pkg;

  localparam int DB_TOP_Y_WORDS = 16;
  localparam int DB_TOP_C_WORDS = 8;
  localparam int DB_TOP_WORDS   = 32;

  localparam logic [1:0] DB_COMP_Y  = 2'd0;
  localparam logic [1:0] DB_COMP_CB = 2'd1;
  localparam logic [1:0] DB_COMP_CR = 2'd2;

  typedef enum logic [1:0] {
    FETCH_IDLE  = 2'd0,
    FETCH_RUN   = 2'd1,
    FETCH_DRAIN = 2'd2
  } fetch_state_e;

  // Colour component of a top-row word: luma words first, then Cb, then Cr.
  function automatic logic [1:0] db_comp_of_idx(input logic [4:0] idx,
                                                input int       y_words,
                                                input int       c_words);
    logic [1:0] comp;
    if (int'(idx) < y_words) begin
      comp = DB_COMP_Y;
    end else if (int'(idx) < (y_words + c_words)) begin
      comp = DB_COMP_CB;
    end else begin
      comp = DB_COMP_CR;
    end
    return comp;
  endfunction

endpackage

// File: rtl/db_skid_fifo2.sv
// 2-entry registered FIFO; the head entry is presented combinationally on head_o.
module db_skid_fifo2 #(
  parameter int WIDTH = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [1:0]       count_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] mem_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             push_s, pop_s;

  assign full_o  = (cnt_q == 2'd2);
  assign empty_o = (cnt_q == 2'd0);
  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A push into a full FIFO is only taken when the head leaves on the same edge.
  assign push_s = push_i && (!full_o || pop_i);
  assign pop_s  = pop_i && !empty_o;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d[0] = mem_q[0];
    mem_d[1] = mem_q[1];
    if (push_s) begin
      mem_d[wr_ptr_q] = push_data_i;
      wr_ptr_d        = ~wr_ptr_q;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = ~rd_ptr_q;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage and pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      mem_q[0] <= mem_d[0];
      mem_q[1] <= mem_d[1];
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  db_skid_fifo2_chk u_chk (
    .clk    (clk),
    .rst    (rst),
    .push_i (push_i),
    .full_i (full_o)
  );

endmodule

// File: rtl/db_skid_fifo2_chk.sv
// Checker for the 2-entry skid FIFO: a push must never arrive while it is full.
module db_skid_fifo2_chk (
  input logic clk,
  input logic rst,
  input logic push_i,
  input logic full_i
);

  // Overflow would silently overwrite the oldest unread word.
  a_no_push_when_full: assert property (@(posedge clk) disable iff (rst) !(push_i && full_i))
    else $error("db_skid_fifo2: push while full");

endmodule

// File: rtl/db_top_fetch.sv
// Top-neighbour read sequencer: streams Y, Cb, Cr top-row words from the RAM
// to the filter core, hiding the RAM read latency with a 2-entry skid FIFO.
module db_top_fetch
  import db_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 5,
  parameter int Y_WORDS    = DB_TOP_Y_WORDS,
  parameter int C_WORDS    = DB_TOP_C_WORDS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  top_avail_i,
  output logic                  ram_cen_o,
  output logic                  ram_ren_o,
  output logic                  ram_wen_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  input  logic [DATA_WIDTH-1:0] ram_data_i,
  output logic                  pix_valid_o,
  input  logic                  pix_ready_i,
  output logic [DATA_WIDTH-1:0] pix_data_o,
  output logic [4:0]            pix_idx_o,
  output logic [1:0]            pix_comp_o,
  output logic                  pix_last_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int                    TOTAL     = Y_WORDS + 2 * C_WORDS;
  localparam logic [ADDR_WIDTH:0]   TOTAL_PTR = (ADDR_WIDTH + 1)'(TOTAL);
  localparam logic [ADDR_WIDTH:0]   LAST_PTR  = (ADDR_WIDTH + 1)'(TOTAL - 1);
  localparam logic [ADDR_WIDTH:0]   PTR_ONE   = (ADDR_WIDTH + 1)'(1);
  localparam logic [4:0]            LAST_IDX  = 5'(TOTAL - 1);

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
  logic                  inflight_q, inflight_d;
  logic [4:0]            out_idx_q, out_idx_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  fifo_empty_s;
  logic                  fifo_full_unused;
  logic [1:0]            fifo_cnt_s;
  logic                  pop_s;
  logic                  issue_s;
  logic [2:0]            credit_s;
  logic                  pix_last_s;

  // Words held or in flight after this edge's pop; reads stop once two are outstanding.
  assign pop_s    = pix_valid_o && pix_ready_i;
  assign credit_s = {1'b0, fifo_cnt_s} + {2'b00, inflight_q} - {2'b00, pop_s};
  assign issue_s  = (state_q == FETCH_RUN) && (rd_ptr_q < TOTAL_PTR) && (credit_s < 3'd2);

  assign ram_cen_o  = ~issue_s;
  assign ram_ren_o  = ~busy_q;
  assign ram_wen_o  = 1'b1;
  assign ram_addr_o = rd_ptr_q[ADDR_WIDTH-1:0];

  assign pix_valid_o = ~fifo_empty_s;
  assign pix_idx_o   = out_idx_q;
  assign pix_comp_o  = db_comp_of_idx(out_idx_q, Y_WORDS, C_WORDS);
  assign pix_last_s  = (out_idx_q == LAST_IDX);
  assign pix_last_o  = pix_last_s;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

  // Sequencer next-state: start handling, read issue and end-of-stream detection.
  always_comb begin
    state_d    = state_q;
    rd_ptr_d   = rd_ptr_q;
    inflight_d = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    if (pop_s) begin
      out_idx_d = out_idx_q + 5'd1;
    end else begin
      out_idx_d = out_idx_q;
    end
    case (state_q)
      FETCH_IDLE: begin
        if (start_i) begin
          if (top_avail_i) begin
            state_d   = FETCH_RUN;
            busy_d    = 1'b1;
            rd_ptr_d  = '0;
            out_idx_d = 5'd0;
          end else begin
            done_d = 1'b1;
          end
        end else begin
          state_d = FETCH_IDLE;
        end
      end
      FETCH_RUN: begin
        if (issue_s) begin
          rd_ptr_d   = rd_ptr_q + PTR_ONE;
          inflight_d = 1'b1;
          if (rd_ptr_q == LAST_PTR) begin
            state_d = FETCH_DRAIN;
          end else begin
            state_d = FETCH_RUN;
          end
        end else begin
          inflight_d = 1'b0;
        end
      end
      FETCH_DRAIN: begin
        if (pop_s && pix_last_s) begin
          state_d = FETCH_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = FETCH_DRAIN;
        end
      end
      default: begin
        state_d = FETCH_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Sequencer state, counters and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FETCH_IDLE;
      rd_ptr_q   <= '0;
      inflight_q <= 1'b0;
      out_idx_q  <= 5'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      inflight_q <= inflight_d;
      out_idx_q  <= out_idx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // A read issued last edge returns its word now; capture it.
  db_skid_fifo2 #(
    .WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (inflight_q),
    .push_data_i (ram_data_i),
    .pop_i       (pop_s),
    .head_o      (pix_data_o),
    .full_o      (fifo_full_unused),
    .empty_o     (fifo_empty_s),
    .count_o     (fifo_cnt_s)
  );

endmodule

// File: tb/tb_db_top_fetch.sv
// Self-checking bench for db_top_fetch with a registered-read RAM model.
module tb_db_top_fetch;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_i;
  logic         top_avail_i;
  logic         ram_cen_o, ram_ren_o, ram_wen_o;
  logic [4:0]   ram_addr_o;
  logic [127:0] ram_data_i;
  logic         pix_valid_o;
  logic         pix_ready_i;
  logic [127:0] pix_data_o;
  logic [4:0]   pix_idx_o;
  logic [1:0]   pix_comp_o;
  logic         pix_last_o;
  logic         busy_o, done_o;

  int total = 0;
  int bad   = 0;

  logic [127:0] mem [32];
  int reads_cnt = 0;
  int pops_cnt  = 0;
  int done_cnt  = 0;

  db_top_fetch dut (
    .clk(clk), .rst(rst), .start_i(start_i), .top_avail_i(top_avail_i),
    .ram_cen_o(ram_cen_o), .ram_ren_o(ram_ren_o), .ram_wen_o(ram_wen_o),
    .ram_addr_o(ram_addr_o), .ram_data_i(ram_data_i),
    .pix_valid_o(pix_valid_o), .pix_ready_i(pix_ready_i), .pix_data_o(pix_data_o),
    .pix_idx_o(pix_idx_o), .pix_comp_o(pix_comp_o), .pix_last_o(pix_last_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  // RAM with one-cycle registered read
  always @(posedge clk) begin
    if (!ram_cen_o) ram_data_i <= mem[ram_addr_o];
  end

  // event counters sampled at the clock edge
  always @(posedge clk) begin
    if (!rst) begin
      if (!ram_cen_o) reads_cnt++;
      if (pix_valid_o && pix_ready_i) pops_cnt++;
      if (done_o) done_cnt++;
    end
  end

  wire logic [136:0] obs_beat = {pix_valid_o, pix_idx_o, pix_comp_o, pix_last_o, pix_data_o};

  // reference: word k of the stream is RAM word k; component by word range
  function automatic logic [1:0] exp_comp(input int k);
    if (k < 16) return 2'd0;
    else if (k < 24) return 2'd1;
    else return 2'd2;
  endfunction

  function automatic logic [136:0] exp_beat(input int k);
    return {1'b1, 5'(k), exp_comp(k), (k == 31), mem[k]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic avail);
    start_i = 1'b1;
    top_avail_i = avail;
    step();
    start_i = 1'b0;
  endtask

  task automatic fill_random();
    for (int k = 0; k < 32; k++) mem[k] = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic test_reset();
    rst = 1'b1; start_i = 1'b0; top_avail_i = 1'b0; pix_ready_i = 1'b0;
    step(); step();
    total++;
    if ({ram_cen_o, ram_ren_o, ram_wen_o, ram_addr_o, pix_valid_o, busy_o, done_o} !== {3'b111, 5'd0, 3'b000}) begin
      bad++;
      $display("FAIL reset_state: got cen/ren/wen/addr/valid/busy/done=%b required %b",
               {ram_cen_o, ram_ren_o, ram_wen_o, ram_addr_o, pix_valid_o, busy_o, done_o}, {3'b111, 5'd0, 3'b000});
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_full_rate();
    int r0, d0;
    for (int k = 0; k < 32; k++) mem[k] = {16{8'(k)}};
    pix_ready_i = 1'b1;
    r0 = reads_cnt; d0 = done_cnt;
    pulse_start(1'b1);
    total++;
    if ({pix_valid_o, busy_o} !== 2'b01) begin
      bad++; $display("FAIL fr_after_start: valid/busy=%b required 01", {pix_valid_o, busy_o});
    end
    step();
    total++;
    if ({pix_valid_o, ram_ren_o} !== 2'b00) begin
      bad++; $display("FAIL fr_latency: valid/ren=%b required 00", {pix_valid_o, ram_ren_o});
    end
    step();
    for (int k = 0; k < 32; k++) begin
      total++;
      if (obs_beat !== exp_beat(k)) begin
        bad++; $display("FAIL fr_beat%0d: got %h required %h", k, obs_beat, exp_beat(k));
      end
      step();
    end
    total++;
    if ({done_o, busy_o, pix_valid_o} !== 3'b100) begin
      bad++; $display("FAIL fr_done: done/busy/valid=%b required 100", {done_o, busy_o, pix_valid_o});
    end
    step();
    total++;
    if ((reads_cnt - r0) != 32 || (done_cnt - d0) != 1) begin
      bad++; $display("FAIL fr_counts: reads=%0d dones=%0d required 32 1", reads_cnt - r0, done_cnt - d0);
    end
  endtask

  task automatic test_backpressure();
    int r0, p0, d0, k, ahead;
    logic stall;
    logic [136:0] held;
    fill_random();
    pix_ready_i = 1'b0;
    r0 = reads_cnt; p0 = pops_cnt; d0 = done_cnt;
    pulse_start(1'b1);
    k = 0; stall = 1'b0; held = '0;
    for (int c = 0; c < 600 && k < 32; c++) begin
      if (stall) begin
        total++;
        if (obs_beat !== held) begin
          bad++; $display("FAIL bp_stall_hold: got %h required %h", obs_beat, held);
        end
      end
      if (pix_valid_o) begin
        total++;
        if (obs_beat !== exp_beat(k)) begin
          bad++; $display("FAIL bp_beat%0d: got %h required %h", k, obs_beat, exp_beat(k));
        end
      end
      ahead = (reads_cnt - r0) - (pops_cnt - p0);
      total++;
      if (ahead > 2 || ahead < 0) begin
        bad++; $display("FAIL bp_read_ahead: got %0d required 0..2", ahead);
      end
      pix_ready_i = 1'($urandom_range(0, 1));
      stall = pix_valid_o && !pix_ready_i;
      held = obs_beat;
      if (pix_valid_o && pix_ready_i) k++;
      step();
    end
    total++;
    if (k != 32) begin
      bad++; $display("FAIL bp_timeout: beats=%0d required 32", k);
    end
    total++;
    if (done_o !== 1'b1) begin
      bad++; $display("FAIL bp_done: got %b required 1", done_o);
    end
    pix_ready_i = 1'b0;
    step();
    total++;
    if ((reads_cnt - r0) != 32 || (done_cnt - d0) != 1) begin
      bad++; $display("FAIL bp_counts: reads=%0d dones=%0d required 32 1", reads_cnt - r0, done_cnt - d0);
    end
  endtask

  task automatic test_no_top();
    int r0, p0, d0;
    r0 = reads_cnt; p0 = pops_cnt; d0 = done_cnt;
    pix_ready_i = 1'b1;
    pulse_start(1'b0);
    total++;
    if ({done_o, busy_o, pix_valid_o} !== 3'b100) begin
      bad++; $display("FAIL nt_done: done/busy/valid=%b required 100", {done_o, busy_o, pix_valid_o});
    end
    step();
    total++;
    if (done_o !== 1'b0) begin
      bad++; $display("FAIL nt_done_pulse: got %b required 0", done_o);
    end
    step(); step(); step();
    total++;
    if ((reads_cnt - r0) != 0 || (pops_cnt - p0) != 0 || (done_cnt - d0) != 1) begin
      bad++; $display("FAIL nt_counts: reads=%0d beats=%0d dones=%0d required 0 0 1",
                      reads_cnt - r0, pops_cnt - p0, done_cnt - d0);
    end
  endtask

  task automatic test_restart_ignored();
    int r0, d0;
    fill_random();
    pix_ready_i = 1'b1;
    r0 = reads_cnt; d0 = done_cnt;
    pulse_start(1'b1);
    step(); step();
    for (int k = 0; k < 32; k++) begin
      total++;
      if (obs_beat !== exp_beat(k)) begin
        bad++; $display("FAIL rs_beat%0d: got %h required %h", k, obs_beat, exp_beat(k));
      end
      start_i = (k == 10);
      top_avail_i = 1'b1;
      step();
    end
    start_i = 1'b0;
    step(); step(); step();
    total++;
    if ((reads_cnt - r0) != 32 || (done_cnt - d0) != 1 || pix_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      bad++; $display("FAIL rs_counts: reads=%0d dones=%0d valid=%b busy=%b required 32 1 0 0",
                      reads_cnt - r0, done_cnt - d0, pix_valid_o, busy_o);
    end
  endtask

  task automatic test_reset_mid();
    int d0, k;
    fill_random();
    pix_ready_i = 1'b1;
    pulse_start(1'b1);
    step(); step();
    for (int j = 0; j < 20; j++) step();
    total++;
    if (obs_beat !== exp_beat(20)) begin
      bad++; $display("FAIL rm_beat20: got %h required %h", obs_beat, exp_beat(20));
    end
    pix_ready_i = 1'b0;
    rst = 1'b1;
    d0 = done_cnt;
    step();
    rst = 1'b0;
    total++;
    if ({pix_valid_o, ram_cen_o, busy_o, done_o} !== 4'b0100) begin
      bad++; $display("FAIL rm_after_reset: valid/cen/busy/done=%b required 0100",
                      {pix_valid_o, ram_cen_o, busy_o, done_o});
    end
    step(); step();
    total++;
    if ((done_cnt - d0) != 0) begin
      bad++; $display("FAIL rm_no_done: dones=%0d required 0", done_cnt - d0);
    end
    fill_random();
    pix_ready_i = 1'b1;
    pulse_start(1'b1);
    k = 0;
    for (int c = 0; c < 100 && k < 32; c++) begin
      if (pix_valid_o) begin
        total++;
        if (obs_beat !== exp_beat(k)) begin
          bad++; $display("FAIL rm_restart_beat%0d: got %h required %h", k, obs_beat, exp_beat(k));
        end
        k++;
      end
      step();
    end
    total++;
    if (k != 32 || done_o !== 1'b1) begin
      bad++; $display("FAIL rm_restart_end: beats=%0d done=%b required 32 1", k, done_o);
    end
    step();
  endtask

  task automatic test_long_stall();
    int r0, p0, k;
    fill_random();
    pix_ready_i = 1'b0;
    r0 = reads_cnt; p0 = pops_cnt;
    pulse_start(1'b1);
    for (int c = 0; c < 10 && !pix_valid_o; c++) step();
    total++;
    if (pix_valid_o !== 1'b1) begin
      bad++; $display("FAIL ls_first_valid: got %b required 1", pix_valid_o);
    end
    for (int c = 0; c < 10; c++) step();
    total++;
    if ((reads_cnt - r0) != 2) begin
      bad++; $display("FAIL ls_reads_stalled: reads=%0d required 2", reads_cnt - r0);
    end
    total++;
    if (obs_beat !== exp_beat(0)) begin
      bad++; $display("FAIL ls_head_held: got %h required %h", obs_beat, exp_beat(0));
    end
    pix_ready_i = 1'b1;
    k = 0;
    for (int c = 0; c < 100 && k < 32; c++) begin
      if (pix_valid_o) begin
        total++;
        if (obs_beat !== exp_beat(k)) begin
          bad++; $display("FAIL ls_beat%0d: got %h required %h", k, obs_beat, exp_beat(k));
        end
        k++;
      end
      step();
    end
    step();
    total++;
    if (k != 32 || (reads_cnt - r0) != 32 || (pops_cnt - p0) != 32) begin
      bad++; $display("FAIL ls_counts: beats=%0d reads=%0d pops=%0d required 32 32 32",
                      k, reads_cnt - r0, pops_cnt - p0);
    end
  endtask

  initial begin
    test_reset();
    test_full_rate();
    test_backpressure();
    test_no_top();
    test_restart_ignored();
    test_reset_mid();
    test_long_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
